// File: rtl/j_ldarb_pkg.sv
// Shared types and constants for the Jerry load-enable arbiter.
// Optional bus-turnaround state is selected by J_LDARB_HOLDOFF_EN.
package j_ldarb_pkg;

    localparam int unsigned NREQ_DEF = 3;
    localparam int unsigned NREG_DEF = 8;
    localparam int unsigned AW_DEF   = 3;
    localparam int unsigned DW_DEF   = 16;

    // Widest register bank the address decoder can serve.
    localparam int unsigned LD_MAXW  = 64;

`ifdef J_LDARB_HOLDOFF_EN
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        HOLD = 2'b10
    } state_e;
`else
    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;
`endif

    // One-hot register select; all-zero when the address is outside the bank.
    function automatic logic [LD_MAXW-1:0] onehot_dec(input logic [31:0] a,
                                                      input int unsigned nreg);
        logic [LD_MAXW-1:0] v;
        v = '0;
        if ((a < nreg) && (a < LD_MAXW)) begin
            v[a[5:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/j_ldarb_rrpick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module j_rrpick
    import j_ldarb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any_c,
    output logic [PW-1:0]   win_c
);

    always_comb begin
        int unsigned idx;
        idx   = 0;
        any_c = 1'b0;
        win_c = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!any_c && req[PW'(idx)]) begin
                any_c = 1'b1;
                win_c = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/j_ldarb.sv
// Round-robin arbiter and load sequencer for Jerry's load-enable register bank.
// Define J_LDARB_HOLDOFF_EN to insert a one-cycle HOLD turnaround after every load.
module j_ldarb
    import j_ldarb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic                 sys_clk,
    input  logic                 resetl,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREG-1:0]      ld,
    output logic [DW-1:0]        ld_data,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q;
    state_e          state_d;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_d;
    logic [NREQ-1:0] gnt_d;
    logic [NREG-1:0] ld_d;
    logic [DW-1:0]   ld_data_d;
    logic            busy_d;
    logic            err_d;
    logic            grant;

    logic [NREQ-1:0] pick_req;
    logic            pick_any;
    logic [PW-1:0]   pick_win;

    logic [AW-1:0]   addr_a [NREQ];
    logic [DW-1:0]   data_a [NREQ];
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;
    logic            win_oor;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            addr_a[i] = addr[i*AW +: AW];
            data_a[i] = data[i*DW +: DW];
        end
    end

    // The requester being granted right now still holds req for this cycle.
    assign pick_req = (state_q == LOAD) ? (req & ~gnt) : req;

    j_rrpick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (pick_req),
        .ptr   (ptr_q),
        .any_c (pick_any),
        .win_c (pick_win)
    );

    assign win_addr = addr_a[pick_win];
    assign win_data = data_a[pick_win];
    assign win_oor  = (32'(win_addr) >= NREG);

    // Next state and next registered outputs.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = '0;
        ld_d      = '0;
        ld_data_d = '0;
        err_d     = err;
        grant     = 1'b0;

        case (state_q)
            IDLE: begin
                grant   = pick_any;
                state_d = pick_any ? LOAD : IDLE;
            end
`ifdef J_LDARB_HOLDOFF_EN
            LOAD: begin
                state_d = HOLD;
            end
            HOLD: begin
                grant   = pick_any;
                state_d = pick_any ? LOAD : IDLE;
            end
`else
            LOAD: begin
                grant   = pick_any;
                state_d = pick_any ? LOAD : IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant) begin
            gnt_d[pick_win] = 1'b1;
            ld_d            = NREG'(onehot_dec(32'(win_addr), NREG));
            ld_data_d       = win_oor ? '0 : win_data;
            err_d           = err | win_oor;
            ptr_d           = (pick_win == PW'(NREQ - 1)) ? '0 : (pick_win + PW'(1));
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt     <= '0;
            ld      <= '0;
            ld_data <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt     <= gnt_d;
            ld      <= ld_d;
            ld_data <= ld_data_d;
            busy    <= busy_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_j_ldarb.sv
// Self-checking bench for j_ldarb (NREG=6 so out-of-range addresses are reachable).
// Honours J_LDARB_HOLDOFF_EN when the design is built with it.
module tb_j_ldarb;

    localparam int unsigned NREQ = 3;
    localparam int unsigned NREG = 6;
    localparam int unsigned AW   = 3;
    localparam int unsigned DW   = 16;
`ifdef J_LDARB_HOLDOFF_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic                 sys_clk = 1'b0;
    logic                 resetl;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*DW-1:0]   data;
    logic [NREQ-1:0]      gnt;
    logic [NREG-1:0]      ld;
    logic [DW-1:0]        ld_data;
    logic                 busy;
    logic                 err;

    j_ldarb #(
        .NREQ (NREQ),
        .NREG (NREG),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .req     (req),
        .addr    (addr),
        .data    (data),
        .gnt     (gnt),
        .ld      (ld),
        .ld_data (ld_data),
        .busy    (busy),
        .err     (err)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: what the outputs should show in the next cycle.
    logic [NREQ-1:0] m_gnt;
    logic [NREG-1:0] m_ld;
    logic [DW-1:0]   m_ldd;
    logic            m_busy;
    logic            m_err;
    int              m_ptr;

    function automatic void model_reset();
        m_gnt  = '0;
        m_ld   = '0;
        m_ldd  = '0;
        m_busy = 1'b0;
        m_err  = 1'b0;
        m_ptr  = 0;
    endfunction

    function automatic void model_step();
        logic [NREQ-1:0] elig;
        int              w;
        int              a;
        if (HOLD_EN && (m_gnt != '0)) begin
            m_gnt  = '0;
            m_ld   = '0;
            m_ldd  = '0;
            m_busy = 1'b1;
            return;
        end
        elig = req & ~m_gnt;
        w    = -1;
        for (int k = 0; k < int'(NREQ); k++) begin
            int i;
            i = (m_ptr + k) % int'(NREQ);
            if (w < 0 && elig[i]) w = i;
        end
        m_gnt = '0;
        m_ld  = '0;
        m_ldd = '0;
        if (w < 0) begin
            m_busy = 1'b0;
        end else begin
            a        = int'(addr[w*AW +: AW]);
            m_gnt[w] = 1'b1;
            if (a < int'(NREG)) begin
                m_ld[a] = 1'b1;
                m_ldd   = data[w*DW +: DW];
            end else begin
                m_err = 1'b1;
            end
            m_busy = 1'b1;
            m_ptr  = (w + 1) % int'(NREQ);
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_model(input string nm);
        chk({nm, ".gnt"},  64'(gnt),     64'(m_gnt));
        chk({nm, ".ld"},   64'(ld),      64'(m_ld));
        chk({nm, ".ldd"},  64'(ld_data), 64'(m_ldd));
        chk({nm, ".busy"}, 64'(busy),    64'(m_busy));
        chk({nm, ".err"},  64'(err),     64'(m_err));
    endtask

    task automatic do_reset();
        resetl = 1'b0;
        req    = '0;
        @(posedge sys_clk);
        #1;
        resetl = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [NREQ-1:0]    req;
        logic [NREQ*AW-1:0] addr;
        logic [NREQ*DW-1:0] data;
        logic [NREQ-1:0]    gnt;
        logic [NREG-1:0]    ld;
        logic [DW-1:0]      ldd;
        logic               busy;
        logic               err;
    } row_t;

    row_t tbl[$];

    function automatic void add(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a,
                                input logic [NREQ*DW-1:0] d, input logic [NREQ-1:0] g,
                                input logic [NREG-1:0] l, input logic [DW-1:0] ldd,
                                input logic b, input logic e);
        row_t x;
        x.req = r; x.addr = a; x.data = d; x.gnt = g;
        x.ld = l; x.ldd = ldd; x.busy = b; x.err = e;
        tbl.push_back(x);
    endfunction

    logic [NREQ*AW-1:0] a3;
    logic [NREQ*DW-1:0] d3;
    logic [NREQ-1:0]    seen_last;
    int                 others;
    bit                 got2;
    bit                 drop_pending;

    initial begin
        resetl = 1'b0;
        req    = 3'b111;
        a3     = {3'd3, 3'd2, 3'd1};
        d3     = {16'h3333, 16'h2222, 16'h1111};
        addr   = a3;
        data   = d3;
        seen_last = '0;
        model_reset();

        // Reset holds everything quiet even with all requests raised.
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst.gnt",  64'(gnt),     64'h0);
        chk("rst.ld",   64'(ld),      64'h0);
        chk("rst.ldd",  64'(ld_data), 64'h0);
        chk("rst.busy", 64'(busy),    64'h0);
        chk("rst.err",  64'(err),     64'h0);

        resetl = 1'b1;
        tick();
        chk("release.gnt", 64'(gnt), 64'h1);
        chk("release.ld",  64'(ld),  64'h02);

        // Abort mid-LOAD: strobes drop without waiting for a clock.
        #2;
        resetl = 1'b0;
        #1;
        chk("abort.gnt",  64'(gnt),     64'h0);
        chk("abort.ld",   64'(ld),      64'h0);
        chk("abort.ldd",  64'(ld_data), 64'h0);
        chk("abort.busy", 64'(busy),    64'h0);
        model_reset();
        @(posedge sys_clk);
        #1;
        resetl = 1'b1;
        tick();
        chk("abort.ptr0_gnt", 64'(gnt), 64'h1);
        do_reset();

        // Directed table: all-three rotation, single load, out-of-range, boundary.
        for (int g = 0; g < 6; g++) begin
            int w;
            logic [NREQ-1:0] gg;
            logic [NREG-1:0] ll;
            w  = g % 3;
            gg = '0;
            gg[w] = 1'b1;
            ll = '0;
            ll[w+1] = 1'b1;
            add(3'b111, a3, d3, gg, ll, 16'(16'h1111 * (w + 1)), 1'b1, 1'b0);
            if (HOLD_EN && g < 5) add(3'b111, a3, d3, 3'b000, '0, '0, 1'b1, 1'b0);
        end
        add(3'b100, a3, d3, 3'b000, '0, '0, HOLD_EN, 1'b0);
        add(3'b000, a3, d3, 3'b000, '0, '0, 1'b0, 1'b0);
        add(3'b010, {3'd0, 3'd5, 3'd0}, {16'h0, 16'hBEEF, 16'h0}, 3'b010, 6'h20, 16'hBEEF, 1'b1, 1'b0);
        add(3'b010, {3'd0, 3'd5, 3'd0}, {16'h0, 16'hBEEF, 16'h0}, 3'b000, '0, '0, HOLD_EN, 1'b0);
        add(3'b000, {3'd0, 3'd5, 3'd0}, {16'h0, 16'hBEEF, 16'h0}, 3'b000, '0, '0, 1'b0, 1'b0);
        add(3'b100, {3'd7, 3'd0, 3'd0}, {16'hCAFE, 16'h0, 16'h0}, 3'b100, '0, '0, 1'b1, 1'b1);
        add(3'b100, {3'd7, 3'd0, 3'd0}, {16'hCAFE, 16'h0, 16'h0}, 3'b000, '0, '0, HOLD_EN, 1'b1);
        add(3'b000, {3'd7, 3'd0, 3'd0}, {16'hCAFE, 16'h0, 16'h0}, 3'b000, '0, '0, 1'b0, 1'b1);
        add(3'b001, {3'd0, 3'd0, 3'd3}, {16'h0, 16'h0, 16'h1234}, 3'b001, 6'h08, 16'h1234, 1'b1, 1'b1);
        add(3'b001, {3'd0, 3'd0, 3'd3}, {16'h0, 16'h0, 16'h1234}, 3'b000, '0, '0, HOLD_EN, 1'b1);
        add(3'b000, {3'd0, 3'd0, 3'd3}, {16'h0, 16'h0, 16'h1234}, 3'b000, '0, '0, 1'b0, 1'b1);
        add(3'b010, {3'd0, 3'd6, 3'd0}, {16'h0, 16'h5A5A, 16'h0}, 3'b010, '0, '0, 1'b1, 1'b1);
        add(3'b010, {3'd0, 3'd6, 3'd0}, {16'h0, 16'h5A5A, 16'h0}, 3'b000, '0, '0, HOLD_EN, 1'b1);
        add(3'b000, {3'd0, 3'd6, 3'd0}, {16'h0, 16'h5A5A, 16'h0}, 3'b000, '0, '0, 1'b0, 1'b1);

        foreach (tbl[i]) begin
            req  = tbl[i].req;
            addr = tbl[i].addr;
            data = tbl[i].data;
            tick();
            chk($sformatf("tbl%0d.gnt", i),  64'(gnt),     64'(tbl[i].gnt));
            chk($sformatf("tbl%0d.ld", i),   64'(ld),      64'(tbl[i].ld));
            chk($sformatf("tbl%0d.ldd", i),  64'(ld_data), 64'(tbl[i].ldd));
            chk($sformatf("tbl%0d.busy", i), 64'(busy),    64'(tbl[i].busy));
            chk($sformatf("tbl%0d.err", i),  64'(err),     64'(tbl[i].err));
        end

        // Only reset clears the sticky error.
        do_reset();
        chk("err_clear", 64'(err), 64'h0);

        // Fairness: req[0] never lets go, req[2] arrives late.
        addr = a3;
        data = d3;
        req  = 3'b001;
        others = 0;
        got2 = 1'b0;
        drop_pending = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c == 3) req[2] = 1'b1;
            tick();
            check_model($sformatf("fair%0d", c));
            if (c >= 3 && !got2) begin
                if (gnt[2]) got2 = 1'b1;
                else if (gnt != '0) others++;
            end
            if (drop_pending) req[2] = 1'b0;
            drop_pending = gnt[2];
        end
        chk("fair.granted", 64'(got2), 64'h1);
        chk("fair.wait_le_2", 64'(others <= 2), 64'h1);

        // Randomized traffic against the model, with occasional resets.
        do_reset();
        seen_last = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 399) == 0) begin
                resetl = 1'b0;
                #1;
                chk("rnd_rst.gnt", 64'(gnt), 64'h0);
                chk("rnd_rst.err", 64'(err), 64'h0);
                model_reset();
                seen_last = '0;
                @(posedge sys_clk);
                #1;
                resetl = 1'b1;
            end
            for (int i = 0; i < int'(NREQ); i++) begin
                if (m_gnt[i]) begin
                    // hold everything while the grant is visible
                end else if (seen_last[i]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        req[i] = 1'b0;
                    end else begin
                        addr[i*AW +: AW] = 3'($urandom_range(0, 7));
                        data[i*DW +: DW] = 16'($urandom);
                    end
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i]           = 1'b1;
                    addr[i*AW +: AW] = 3'($urandom_range(0, 7));
                    data[i*DW +: DW] = 16'($urandom);
                end
                seen_last[i] = m_gnt[i];
            end
            tick();
            check_model($sformatf("rnd%0d", cyc));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
